hams_sort_sched: RTL and testbench

- Batch scheduler in front of hams_sortNelem.
- Collects a serial element stream into NUM_ELEMENTS-wide batches and issues each batch to the sorter with a one-cycle valid.
- Tracks in-flight batches and captures every valid_o vector into an output buffer, then streams sorted elements back out one per cycle.
- Credit-based issue guarantees no sorted vector is ever dropped, because the sorter has no backpressure.

---
 rtl/hams_sort_sched.sv | 95 +++++++++
 tb/tb_hams_sort_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hams_sort_sched.sv
// hams_sort_sched: batches a serial element stream for hams_sortNelem and streams sorted results back out
module hams_sort_sched #(
  parameter int NUM_ELEMENTS = 8,
  parameter int PAIR_W = 16,
  parameter int OUT_SLOTS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [PAIR_W-1:0] in_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_flush,
  output logic [NUM_ELEMENTS*PAIR_W-1:0] srt_unsorted,
  output logic srt_valid,
  input  logic [NUM_ELEMENTS*PAIR_W-1:0] srt_sorted,
  input  logic srt_valid_o,
  output logic [PAIR_W-1:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic busy
);
  localparam int FW = $clog2(NUM_ELEMENTS + 1);
  localparam int IW = $clog2(NUM_ELEMENTS);
  localparam int CW = $clog2(OUT_SLOTS + 1);
  localparam int PW = OUT_SLOTS > 1 ? $clog2(OUT_SLOTS) : 1;
  typedef enum logic {FILL, ISSUE} state_t;
  state_t state_q, state_d;
  logic [PAIR_W-1:0] slot [NUM_ELEMENTS];
  logic [NUM_ELEMENTS*PAIR_W-1:0] vec_mem [OUT_SLOTS];
  logic [FW-1:0] cnt_mem [OUT_SLOTS];
  logic [NUM_ELEMENTS*PAIR_W-1:0] batch, head;
  logic [FW-1:0] fill_q, head_cnt;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] inflight_q, occ_q;
  logic [PW-1:0] cw_ptr, vw_ptr, rd_ptr;
  logic run_q, accept, seal, cap, xfer, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OUT_SLOTS - 1) ? '0 : p + 1'b1;
  endfunction
  // credit counts the batch being filled, so a sorted vector always has a buffer slot
  assign in_ready = run_q && state_q == FILL &&
                    ({1'b0, inflight_q} + {1'b0, occ_q}) < (CW+1)'(OUT_SLOTS);
  assign accept = in_valid && in_ready;
  assign seal = (accept && fill_q == FW'(NUM_ELEMENTS - 1)) ||
                (in_ready && in_flush && (accept || fill_q != '0));
  assign cap = srt_valid_o && inflight_q != '0;
  assign head = vec_mem[rd_ptr];
  assign head_cnt = cnt_mem[rd_ptr];
  assign out_valid = occ_q != '0;
  assign out_last = out_valid && FW'(idx_q) == head_cnt - 1'b1;
  assign out_data = out_valid ? head[idx_q*PAIR_W +: PAIR_W] : '0;
  assign xfer = out_valid && out_ready;
  assign pop = xfer && out_last;
  assign busy = fill_q != '0 || inflight_q != '0 || occ_q != '0 || state_q == ISSUE;
  always_comb begin
    batch = '1;
    for (int i = 0; i < NUM_ELEMENTS; i++)
      if (accept && FW'(i) == fill_q) batch[i*PAIR_W +: PAIR_W] = in_data;
      else if (FW'(i) < fill_q) batch[i*PAIR_W +: PAIR_W] = slot[i];
  end
  always_comb begin
    state_d = seal ? ISSUE : FILL;
    srt_valid = state_q == ISSUE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      run_q <= 1'b0;
      fill_q <= '0;
      idx_q <= '0;
      inflight_q <= '0;
      occ_q <= '0;
      cw_ptr <= '0;
      vw_ptr <= '0;
      rd_ptr <= '0;
      srt_unsorted <= '0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
      fill_q <= state_q == ISSUE ? '0 : accept ? fill_q + 1'b1 : fill_q;
      if (seal) srt_unsorted <= batch;
      if (state_q == ISSUE) cw_ptr <= nxt(cw_ptr);
      if (cap) vw_ptr <= nxt(vw_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      inflight_q <= inflight_q + CW'(state_q == ISSUE) - CW'(cap);
      occ_q <= occ_q + CW'(cap) - CW'(pop);
      if (xfer) idx_q <= pop ? '0 : idx_q + 1'b1;
    end
  always_ff @(posedge clk) begin
    if (accept) slot[fill_q[IW-1:0]] <= in_data;
    if (state_q == ISSUE) cnt_mem[cw_ptr] <= fill_q;
    if (cap) vec_mem[vw_ptr] <= srt_sorted;
  end
endmodule

// File: tb/tb_hams_sort_sched.sv
// tb_hams_sort_sched: directed checks of hams_sort_sched against a behavioural sorter with latency L
module tb_hams_sort_sched;
  localparam int N = 8;
  localparam int W = 16;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_flush = 1'b0, out_ready = 1'b0;
  logic in_ready, srt_valid, srt_valid_o, out_valid, out_last, busy;
  logic [N*W-1:0] srt_unsorted, srt_sorted;
  logic [W-1:0] out_data;
  logic man = 1'b0, man_v = 1'b0;
  logic [N*W-1:0] man_d = '0;
  logic [L-1:0] pv;
  logic [N*W-1:0] pd [L];
  logic [W-1:0] oq [$];
  logic lq [$];
  int n_issue = 0, tb_infl = 0, proto_err = 0;
  int checks = 0, passed = 0, fails = 0, b = 0;

  hams_sort_sched #(.NUM_ELEMENTS(N), .PAIR_W(W), .OUT_SLOTS(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_flush(in_flush), .srt_unsorted(srt_unsorted), .srt_valid(srt_valid),
    .srt_sorted(srt_sorted), .srt_valid_o(srt_valid_o), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] sort_vec(input logic [N*W-1:0] v);
    logic [W-1:0] a [N];
    logic [W-1:0] t;
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j];
          a[j] = a[j+1];
          a[j+1] = t;
        end
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pv <= '0;
    else begin
      pv <= {pv[L-2:0], srt_valid};
      pd[0] <= sort_vec(srt_unsorted);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
  assign srt_valid_o = man ? man_v : pv[L-1];
  assign srt_sorted = man ? man_d : pd[L-1];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      oq.push_back(out_data);
      lq.push_back(out_last);
    end
    if (srt_valid) n_issue <= n_issue + 1;
  end

  always @(negedge clk or negedge rst_n)
    if (!rst_n) tb_infl <= 0;
    else begin
      if (srt_valid_o && tb_infl == 0) proto_err <= proto_err + 1;
      tb_infl <= tb_infl + int'(srt_valid) - int'(srt_valid_o && tb_infl != 0);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] k, input logic f, input logic v);
    logic ok = 1'b0;
    in_data = k;
    in_valid = v;
    in_flush = f;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
    chk("send_ready", ok, 1);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 300 && oq.size() < b + n; i++) step();
    chk("out_count", oq.size(), b + n);
  endtask

  initial begin
    logic [W-1:0] e4 [N];
    logic [N*W-1:0] vb;
    int acc, ni, pe;
    e4 = '{1, 2, 3, 4, 5, 6, 9, 15};
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_srt_valid", srt_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unsorted", srt_unsorted, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_in_ready", in_ready, 1);

    // full batch, keys descending
    out_ready = 1'b1;
    b = oq.size();
    ni = n_issue;
    for (int k = 8; k >= 1; k--) send(W'(k), 1'b0, 1'b1);
    chk("t1_srt_valid", srt_valid, 1);
    chk("t1_unsorted", srt_unsorted, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    chk("t1_issue_ready", in_ready, 0);
    wait_out(8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", oq[b+i], i + 1);
      chk("t1_last", lq[b+i], i == 7);
    end
    repeat (5) step();
    chk("t1_issues", n_issue - ni, 1);
    chk("t1_busy", busy, 0);
    chk("t1_no_extra", oq.size(), b + 8);

    // partial batch closed by a separate flush
    b = oq.size();
    send(5, 1'b0, 1'b1);
    send(2, 1'b0, 1'b1);
    send(9, 1'b0, 1'b1);
    chk("t2_busy_fill", busy, 1);
    send(0, 1'b1, 1'b0);
    chk("t2_srt_valid", srt_valid, 1);
    chk("t2_unsorted", srt_unsorted, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_0009_0002_0005);
    wait_out(3);
    chk("t2_d0", oq[b], 2);
    chk("t2_d1", oq[b+1], 5);
    chk("t2_d2", oq[b+2], 9);
    chk("t2_l1", lq[b+1], 0);
    chk("t2_l2", lq[b+2], 1);
    repeat (10) step();
    chk("t2_no_pad", oq.size(), b + 3);

    // flush in the same cycle as the only accept
    b = oq.size();
    send(4, 1'b1, 1'b1);
    chk("t2b_srt_valid", srt_valid, 1);
    chk("t2b_unsorted", srt_unsorted, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0004);
    wait_out(1);
    chk("t2b_data", oq[b], 4);
    chk("t2b_last", lq[b], 1);
    repeat (6) step();
    send(0, 1'b1, 1'b0);
    chk("t2c_empty_flush", srt_valid, 0);
    chk("t2c_busy", busy, 0);

    // credit exhaustion with egress stalled
    out_ready = 1'b0;
    b = oq.size();
    ni = n_issue;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      logic r;
      in_data = W'(40 - acc);
      r = in_ready;
      step();
      if (r) acc++;
    end
    in_valid = 1'b0;
    chk("t3_accepts", acc, 16);
    chk("t3_issues", n_issue - ni, 2);
    chk("t3_ready", in_ready, 0);
    chk("t3_head", out_data, 33);
    out_ready = 1'b1;
    repeat (3) step();
    chk("t3_ready3", in_ready, 0);
    chk("t3_data3", out_data, 36);
    repeat (4) step();
    chk("t3_ready7", in_ready, 0);
    chk("t3_last7", out_last, 1);
    chk("t3_data7", out_data, 40);
    step();
    chk("t3_reopen", in_ready, 1);
    chk("t3_next_head", out_data, 25);
    wait_out(16);
    for (int j = 0; j < 16; j++) begin
      chk("t3_data", oq[b+j], j < 8 ? 33 + j : 17 + j);
      chk("t3_last", lq[b+j], j == 7 || j == 15);
    end

    // asynchronous reset with a partial batch and one in flight
    repeat (4) step();
    man = 1'b1;
    man_v = 1'b0;
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) send(W'(k), 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) send(W'(k), 1'b0, 1'b1);
    chk("t4_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_in_ready", in_ready, 0);
    chk("t4_srt_valid", srt_valid, 0);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_out_last", out_last, 0);
    chk("t4_busy0", busy, 0);
    chk("t4_unsorted", srt_unsorted, 0);
    chk("t4_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    man = 1'b0;
    step();
    step();
    b = oq.size();
    out_ready = 1'b1;
    send(3, 1'b0, 1'b1);
    send(1, 1'b0, 1'b1);
    send(4, 1'b0, 1'b1);
    send(15, 1'b0, 1'b1);
    send(9, 1'b0, 1'b1);
    send(2, 1'b0, 1'b1);
    send(6, 1'b0, 1'b1);
    send(5, 1'b0, 1'b1);
    wait_out(8);
    for (int i = 0; i < 8; i++) chk("t4_data", oq[b+i], e4[i]);
    chk("t4_last", lq[b+7], 1);
    repeat (10) step();
    chk("t4_no_stale", oq.size(), b + 8);

    // last pop of one vector coincides with capture of the next
    man = 1'b1;
    out_ready = 1'b0;
    b = oq.size();
    for (int k = 17; k >= 10; k--) send(W'(k), 1'b0, 1'b1);
    step();
    man_d = sort_vec(srt_unsorted);
    man_v = 1'b1;
    step();
    man_v = 1'b0;
    for (int k = 27; k >= 20; k--) send(W'(k), 1'b0, 1'b1);
    step();
    vb = sort_vec(srt_unsorted);
    out_ready = 1'b1;
    repeat (7) step();
    chk("t5_last_a", out_last, 1);
    chk("t5_data_a", out_data, 17);
    man_d = vb;
    man_v = 1'b1;
    step();
    man_v = 1'b0;
    chk("t5_occ_held", out_valid, 1);
    chk("t5_head_b", out_data, 20);
    chk("t5_idx0", out_last, 0);
    wait_out(16);
    for (int j = 0; j < 16; j++) chk("t5_data", oq[b+j], j < 8 ? 10 + j : 12 + j);
    chk("t5_proto", proto_err, 0);

    // spurious sorter strobe while nothing is in flight
    repeat (4) step();
    pe = proto_err;
    b = oq.size();
    man_d = '0;
    man_v = 1'b1;
    step();
    man_v = 1'b0;
    step();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_proto_seen", proto_err - pe, 1);
    man = 1'b0;
    send(7, 1'b1, 1'b1);
    wait_out(1);
    chk("t6_data", oq[b], 7);
    chk("t6_last", lq[b], 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
